// File: rtl/obi_delay_line.sv
`default_nettype none
// ============================================================================
// Module  : obi_delay_line
// Brief   : OBI delay line with elastic request stages, a fixed-latency
//           response chain and an outstanding-transaction limit.
// Option  : define OBI_DELAY_STALL_CNT_EN to enable the downstream stall counter.
// Rev     : 1.0  initial release
// ============================================================================
module obi_delay_line #(
  parameter int DEPTH           = 2,
  parameter int RESP_DEPTH      = 1,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_pipeline,
  input  logic                    req_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    gnt_o,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    req_o,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic                    we_o,
  output logic [DATA_WIDTH/8-1:0] be_o,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  input  logic                    gnt_i,
  input  logic                    rvalid_i,
  input  logic [DATA_WIDTH-1:0]   rdata_i,
  output logic [31:0]             stall_cnt_o
);

  localparam int c_BE_W  = DATA_WIDTH / 8;
  localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [c_CNT_W-1:0] c_MAX_OUT = c_CNT_W'(MAX_OUTSTANDING);

  logic [c_CNT_W-1:0] r_outstanding;
  logic               w_out_ok;
  logic               w_dn_hs;

  assign w_out_ok = (r_outstanding < c_MAX_OUT);
  assign w_dn_hs  = req_o & gnt_i;

  // A response at count zero is a protocol violation; the counter just holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outstanding <= '0;
    end else if (w_dn_hs && !rvalid_i) begin
      r_outstanding <= r_outstanding + 1'b1;
    end else if (!w_dn_hs && rvalid_i && (r_outstanding != '0)) begin
      r_outstanding <= r_outstanding - 1'b1;
    end
  end

  generate
    if (DEPTH == 0) begin : g_req_bypass
      assign req_o   = req_i & w_out_ok;
      assign addr_o  = addr_i;
      assign we_o    = we_i;
      assign be_o    = be_i;
      assign wdata_o = wdata_i;
      assign gnt_o   = gnt_i & w_out_ok & ~clear_pipeline;
    end else begin : g_req_pipe
      logic [DEPTH-1:0]      r_valid;
      logic [DEPTH-1:0]      w_ready;
      logic [DEPTH-1:0]      w_valid_nxt;
      logic [ADDR_WIDTH-1:0] r_addr  [DEPTH];
      logic [DEPTH-1:0]      r_we;
      logic [c_BE_W-1:0]     r_be    [DEPTH];
      logic [DATA_WIDTH-1:0] r_wdata [DEPTH];
      logic                  w_accept;

      assign req_o    = r_valid[DEPTH-1] & w_out_ok;
      assign addr_o   = r_addr[DEPTH-1];
      assign we_o     = r_we[DEPTH-1];
      assign be_o     = r_be[DEPTH-1];
      assign wdata_o  = r_wdata[DEPTH-1];
      assign gnt_o    = w_ready[0] & ~clear_pipeline;
      assign w_accept = req_i & gnt_o;

      for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        // Flattened ready chain: a stage is ready if any stage at or after it has a hole, or the tail pops.
        assign w_ready[k] = w_dn_hs | ~(&r_valid[DEPTH-1:k]);
        if (k == 0) begin : g_head
          assign w_valid_nxt[k] = w_ready[k] ? w_accept : r_valid[k];
        end else begin : g_body
          assign w_valid_nxt[k] = w_ready[k] ? r_valid[k-1] : r_valid[k];
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_valid <= '0;
          r_we    <= '0;
          for (int k = 0; k < DEPTH; k++) begin
            r_addr[k]  <= '0;
            r_be[k]    <= '0;
            r_wdata[k] <= '0;
          end
        end else begin
          if (w_accept) begin
            r_addr[0]  <= addr_i;
            r_we[0]    <= we_i;
            r_be[0]    <= be_i;
            r_wdata[0] <= wdata_i;
          end
          for (int k = 1; k < DEPTH; k++) begin
            if (w_ready[k] && r_valid[k-1]) begin
              r_addr[k]  <= r_addr[k-1];
              r_we[k]    <= r_we[k-1];
              r_be[k]    <= r_be[k-1];
              r_wdata[k] <= r_wdata[k-1];
            end
          end
          // A tail handshake this cycle still completes; everything else is dropped.
          if (clear_pipeline) begin
            r_valid <= '0;
          end else begin
            r_valid <= w_valid_nxt;
          end
        end
      end
    end
  endgenerate

  generate
    if (RESP_DEPTH == 0) begin : g_rsp_bypass
      assign rvalid_o = rvalid_i;
      assign rdata_o  = rdata_i;
    end else begin : g_rsp_pipe
      logic [RESP_DEPTH-1:0] r_rvalid;
      logic [DATA_WIDTH-1:0] r_rdata [RESP_DEPTH];

      assign rvalid_o = r_rvalid[RESP_DEPTH-1];
      assign rdata_o  = r_rdata[RESP_DEPTH-1];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_rvalid <= '0;
          for (int k = 0; k < RESP_DEPTH; k++) begin
            r_rdata[k] <= '0;
          end
        end else begin
          r_rvalid[0] <= rvalid_i;
          if (rvalid_i) begin
            r_rdata[0] <= rdata_i;
          end
          for (int k = 1; k < RESP_DEPTH; k++) begin
            r_rvalid[k] <= r_rvalid[k-1];
            if (r_rvalid[k-1]) begin
              r_rdata[k] <= r_rdata[k-1];
            end
          end
        end
      end
    end
  endgenerate

`ifdef OBI_DELAY_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (req_o && !gnt_i && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_obi_delay_line.sv
`default_nettype none
// ============================================================================
// Module  : tb_obi_delay_line
// Brief   : Scoreboard bench for obi_delay_line with default parameters.
// Rev     : 1.0  initial release
// ============================================================================
module tb_obi_delay_line;

`ifdef OBI_DELAY_STALL_CNT_EN
  localparam logic [31:0] c_STALL = 32'd5;
`else
  localparam logic [31:0] c_STALL = 32'd0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_pipeline = 1'b0;
  logic        req_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = '0;
  logic [31:0] wdata_i = '0;
  logic        gnt_i = 1'b0;
  logic        rvalid_i = 1'b0;
  logic [31:0] rdata_i = '0;
  logic        gnt_o, rvalid_o, req_o, we_o;
  logic [31:0] rdata_o, addr_o, wdata_o, stall_cnt_o;
  logic [3:0]  be_o;

  int total = 0;
  int bad = 0;
  int tb_out = 0;
  logic [68:0] exp_q[$];
  logic [68:0] got_q[$];
  logic [31:0] rsp_exp[$];
  logic [31:0] rsp_got[$];

  always #5 clk_i = ~clk_i;

  obi_delay_line #(
    .DEPTH(2), .RESP_DEPTH(1), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_pipeline(clear_pipeline),
    .req_i(req_i), .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .req_o(req_o), .addr_o(addr_o), .we_o(we_o), .be_o(be_o), .wdata_o(wdata_o),
    .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i), .stall_cnt_o(stall_cnt_o)
  );

  // Expected entries are captured at the upstream handshake, observed ones at the downstream side.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      tb_out <= 0;
    end else begin
      if (req_i && gnt_o) exp_q.push_back({addr_i, we_i, be_i, wdata_i});
      if (req_o && gnt_i) got_q.push_back({addr_o, we_o, be_o, wdata_o});
      if (rvalid_i) rsp_exp.push_back(rdata_i);
      if (rvalid_o) rsp_got.push_back(rdata_o);
      if (req_o && gnt_i && !rvalid_i) tb_out <= tb_out + 1;
      else if (!(req_o && gnt_i) && rvalid_i && tb_out > 0) tb_out <= tb_out - 1;
    end
  end

  // One cycle of stimulus; returns at the following negedge for sampling.
  task automatic drive(input logic rq, input logic [31:0] a, input logic g,
                       input logic rv, input logic [31:0] rd, input logic clr,
                       input logic auto_rsp);
    @(posedge clk_i); #1;
    req_i          = rq;
    addr_i         = a;
    we_i           = a[2];
    be_i           = a[7:4];
    wdata_i        = {a[15:0], ~a[15:0]};
    gnt_i          = g;
    rvalid_i       = auto_rsp ? (tb_out > 0) : rv;
    rdata_i        = rd;
    clear_pipeline = clr;
    @(negedge clk_i);
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b1, 1'b0, $urandom, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    total++; if ({req_o, rvalid_o} !== 2'b00) begin bad++; $display("FAIL reset_valid got=%b exp=00", {req_o, rvalid_o}); end
    total++; if (rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata_o); end
    total++; if ({addr_o, we_o, be_o, wdata_o} !== 69'h0) begin bad++; $display("FAIL reset_payload got=%h exp=0", {addr_o, we_o, be_o, wdata_o}); end
    total++; if (stall_cnt_o !== 32'h0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt_o); end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic exp_req;
    for (int i = 0; i < 7; i++) begin
      drive(i < 3, 32'h100 + 32'(4 * i), 1'b1, 1'b0, $urandom, 1'b0, 1'b1);
      if (i <= 4) begin
        total++; if (gnt_o !== 1'b1) begin bad++; $display("FAIL b2b_gnt cyc=%0d got=%b exp=1", i, gnt_o); end
      end
      exp_req = (i >= 2) && (i <= 4);
      total++; if (req_o !== exp_req) begin bad++; $display("FAIL b2b_req cyc=%0d got=%b exp=%b", i, req_o, exp_req); end
      if (exp_req) begin
        total++; if (addr_o !== 32'h100 + 32'(4 * (i - 2))) begin bad++; $display("FAIL b2b_addr cyc=%0d got=%h exp=%h", i, addr_o, 32'h100 + 32'(4 * (i - 2))); end
      end
      total++; if (rvalid_o !== ((i >= 4) && (i <= 6))) begin bad++; $display("FAIL b2b_rvalid cyc=%0d got=%b", i, rvalid_o); end
    end
    run_idle(4);
  endtask

  task automatic test_stall();
    int idx = 0;
    for (int i = 0; i < 8; i++) begin
      drive(idx < 3, 32'h200 + 32'(4 * idx), i >= 7, 1'b0, 32'h0, 1'b0, 1'b1);
      if (req_i && gnt_o) idx++;
      if (i >= 2 && i <= 6) begin
        total++; if (gnt_o !== 1'b0) begin bad++; $display("FAIL stall_gnt cyc=%0d got=%b exp=0", i, gnt_o); end
        total++; if (req_o !== 1'b1 || addr_o !== 32'h200) begin bad++; $display("FAIL stall_hold cyc=%0d got=%b/%h exp=1/00000200", i, req_o, addr_o); end
      end
      if (i == 7) begin
        total++; if (stall_cnt_o !== c_STALL) begin bad++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt_o, c_STALL); end
        total++; if (gnt_o !== 1'b1) begin bad++; $display("FAIL stall_release got=%b exp=1", gnt_o); end
      end
    end
    total++; if (idx !== 3) begin bad++; $display("FAIL stall_accepted got=%0d exp=3", idx); end
    run_idle(10);
  endtask

  task automatic test_outstanding();
    int idx = 0;
    int hs = 0;
    for (int i = 0; i < 11; i++) begin
      drive(idx < 4, 32'h300 + 32'(4 * idx), 1'b1, i == 8, 32'hDEADBEEF, 1'b0, 1'b0);
      if (req_i && gnt_o) idx++;
      if (req_o && gnt_i) hs++;
      if ((i >= 4 && i <= 8) || i == 10) begin
        total++; if (req_o !== 1'b0) begin bad++; $display("FAIL out_limit cyc=%0d got=%b exp=0", i, req_o); end
      end
      if (i == 8) begin
        total++; if (rvalid_o !== 1'b0) begin bad++; $display("FAIL rsp_early got=%b exp=0", rvalid_o); end
      end
      if (i == 9) begin
        total++; if (rvalid_o !== 1'b1 || rdata_o !== 32'hDEADBEEF) begin bad++; $display("FAIL rsp_latency got=%b/%h exp=1/deadbeef", rvalid_o, rdata_o); end
      end
    end
    total++; if (hs !== 3) begin bad++; $display("FAIL out_handshakes got=%0d exp=3", hs); end
    run_idle(10);
  endtask

  task automatic test_clear();
    drive(1'b1, 32'h600, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h604, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h608, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    total++; if (gnt_o !== 1'b0) begin bad++; $display("FAIL clear_gnt got=%b exp=0", gnt_o); end
    total++; if (req_o !== 1'b1 || addr_o !== 32'h600) begin bad++; $display("FAIL clear_tail got=%b/%h exp=1/00000600", req_o, addr_o); end
    // The entry held in stage 0 (0x604) is flushed and never reaches the bus.
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    drive(1'b1, 32'h700, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    total++; if (req_o !== 1'b0) begin bad++; $display("FAIL clear_drop got=%b exp=0", req_o); end
    drive(1'b1, 32'h704, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    total++; if (req_o !== 1'b1 || addr_o !== 32'h700) begin bad++; $display("FAIL clear_next got=%b/%h exp=1/00000700", req_o, addr_o); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      total++; if (req_o !== 1'b0) begin bad++; $display("FAIL clear_counted cyc=%0d got=%b exp=0", i, req_o); end
    end
    run_idle(10);
  endtask

  task automatic test_reset_mid();
    int idx = 0;
    int hs = 0;
    drive(1'b1, 32'h400, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h404, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    total++; if (stall_cnt_o !== c_STALL) begin bad++; $display("FAIL stall_keep got=%0d exp=%0d", stall_cnt_o, c_STALL); end
    @(posedge clk_i); #1;
    rst_ni = 1'b0; req_i = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b0;
    @(negedge clk_i);
    total++; if ({req_o, rvalid_o, rdata_o} !== 34'h0) begin bad++; $display("FAIL rstmid_out got=%h exp=0", {req_o, rvalid_o, rdata_o}); end
    total++; if ({addr_o, we_o, be_o, wdata_o} !== 69'h0) begin bad++; $display("FAIL rstmid_payload got=%h exp=0", {addr_o, we_o, be_o, wdata_o}); end
    total++; if (stall_cnt_o !== 32'h0) begin bad++; $display("FAIL rstmid_stall got=%0d exp=0", stall_cnt_o); end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    for (int j = 0; j < 8; j++) begin
      drive(idx < 3, 32'h500 + 32'(4 * idx), 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      if (req_i && gnt_o) idx++;
      if (req_o && gnt_i) hs++;
      if (j == 0) begin
        total++; if (req_o !== 1'b0 || rvalid_o !== 1'b0) begin bad++; $display("FAIL rstmid_idle got=%b%b exp=00", req_o, rvalid_o); end
      end
    end
    total++; if (hs !== 2) begin bad++; $display("FAIL rstmid_counter got=%0d exp=2", hs); end
    run_idle(10);
  endtask

  task automatic test_scoreboard();
    logic [68:0] e, g;
    logic [31:0] re, rg;
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL sb_req_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL sb_req got=%h exp=%h", g, e); end
    end
    total++; if (rsp_got.size() != rsp_exp.size()) begin bad++; $display("FAIL sb_rsp_count got=%0d exp=%0d", rsp_got.size(), rsp_exp.size()); end
    while (rsp_got.size() > 0 && rsp_exp.size() > 0) begin
      rg = rsp_got.pop_front();
      re = rsp_exp.pop_front();
      total++; if (rg !== re) begin bad++; $display("FAIL sb_rsp got=%h exp=%h", rg, re); end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_outstanding();
    test_clear();
    test_reset_mid();
    test_scoreboard();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
